uart_cmd_ctrl: RTL and testbench

- Sequences the UART receiver byte stream into 5-byte command packets: SYNC, CMD, DATA_HI, DATA_LO, CHK.
- Owns the receiver's rdy/clr_rdy handshake, validates the checksum, and enforces an inter-byte timeout.
- Presents a held {cmd, data} word with cmd_rdy to the downstream command dispatcher.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_cmd_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command path: packet FSM states,
// default framing byte and bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_HI,
        GET_LO,
        GET_CHK
    } cmd_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CLK_PER_BIT       = 2604;

    // Check byte is the one's complement of the 8-bit running sum.
    function automatic logic [7:0] chk_of(input logic [7:0] sum);
        return ~sum;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Assembles SYNC/CMD/DATA_HI/DATA_LO/CHK packets from the UART receiver,
// validates the checksum, enforces an inter-byte timeout and holds the result.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = 20 * CLK_PER_BIT,
    parameter int         TO_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        chk_err,
    output logic        timeout,
    output logic        overrun
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    cmd_state_t      state_q, state_d;
    logic            clr_rx_rdy_q;
    logic [7:0]      cmd_sh_q, cmd_sh_d;
    logic [7:0]      hi_sh_q, hi_sh_d;
    logic [7:0]      lo_sh_q, lo_sh_d;
    logic [7:0]      sum_q, sum_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [15:0]     data_q, data_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            chk_err_q, chk_err_d;
    logic            timeout_q, timeout_d;
    logic            overrun_q, overrun_d;

    logic            byte_vld;
    logic            to_expire;
    logic            pkt_good;

    // The receiver still shows rdy during the cycle our clear pulse is out.
    assign byte_vld  = rx_rdy & ~clr_rx_rdy_q;
    assign to_expire = (state_q != IDLE) && !byte_vld && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        cmd_sh_d  = cmd_sh_q;
        hi_sh_d   = hi_sh_q;
        lo_sh_d   = lo_sh_q;
        sum_d     = sum_q;
        chk_err_d = 1'b0;
        pkt_good  = 1'b0;
        if (to_expire) begin
            state_d = IDLE;
        end else if (byte_vld) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) state_d = GET_CMD;
                end
                GET_CMD: begin
                    cmd_sh_d = rx_data;
                    sum_d    = rx_data;
                    state_d  = GET_HI;
                end
                GET_HI: begin
                    hi_sh_d = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = GET_LO;
                end
                GET_LO: begin
                    lo_sh_d = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = GET_CHK;
                end
                GET_CHK: begin
                    state_d = IDLE;
                    if (rx_data == chk_of(sum_q)) pkt_good  = 1'b1;
                    else                          chk_err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_d     = cmd_q;
        data_d    = data_q;
        cmd_rdy_d = cmd_rdy_q;
        overrun_d = 1'b0;
        timeout_d = to_expire;
        // A new good packet beats a same-cycle acknowledge.
        if (pkt_good) begin
            cmd_d     = cmd_sh_q;
            data_d    = {hi_sh_q, lo_sh_q};
            cmd_rdy_d = 1'b1;
            overrun_d = cmd_rdy_q;
        end else if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (state_q == IDLE || byte_vld || to_expire) to_cnt_d = '0;
        else                                          to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clr_rx_rdy_q <= 1'b0;
            cmd_sh_q     <= '0;
            hi_sh_q      <= '0;
            lo_sh_q      <= '0;
            sum_q        <= '0;
            to_cnt_q     <= '0;
            cmd_q        <= '0;
            data_q       <= '0;
            cmd_rdy_q    <= 1'b0;
            chk_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_rx_rdy_q <= byte_vld;
            cmd_sh_q     <= cmd_sh_d;
            hi_sh_q      <= hi_sh_d;
            lo_sh_q      <= lo_sh_d;
            sum_q        <= sum_d;
            to_cnt_q     <= to_cnt_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            cmd_rdy_q    <= cmd_rdy_d;
            chk_err_q    <= chk_err_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    assign clr_rx_rdy = clr_rx_rdy_q;
    assign cmd        = cmd_q;
    assign data       = data_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign chk_err    = chk_err_q;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized scoreboard bench for uart_cmd_ctrl: a byte-stream packet model
// predicts good/bad/timeout events, a monitor pops and compares them.
module tb_uart_cmd_ctrl;

    localparam int         T    = 64;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int EV_GOOD = 0, EV_CHK = 1, EV_TO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        chk_err;
    logic        timeout;
    logic        overrun;

    uart_cmd_ctrl #(
        .SYNC_BYTE  (SYNC),
        .TIMEOUT_CYC(T),
        .TO_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .data       (data),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .chk_err    (chk_err),
        .timeout    (timeout),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  cmd;
        logic [15:0] data;
        logic        ovr;
    } ev_t;

    ev_t exp_q[$];
    int  nvec = 0;
    int  nerr = 0;
    // Reference model: bytes collected so far in the current packet.
    int  pos = 0;
    int  pk[3];
    bit  pending = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(input int kind, input int c, input int d, input bit o);
        ev_t e;
        e.kind = 2'(kind);
        e.cmd  = 8'(c);
        e.data = 16'(d);
        e.ovr  = o;
        exp_q.push_back(e);
    endfunction

    // gap+2 is the distance in cycles between this byte's acceptance and the previous one.
    function automatic void model_byte(input int b, input int gap, input bit ack_with);
        bit good = 0;
        if (pos > 0 && gap + 2 > T) begin
            push_ev(EV_TO, 0, 0, 0);
            pos = 0;
        end
        if (pos == 0) begin
            if (b == int'(SYNC)) pos = 1;
        end else if (pos < 4) begin
            pk[pos-1] = b;
            pos++;
        end else begin
            pos = 0;
            if (b == 255 - ((pk[0] + pk[1] + pk[2]) % 256)) begin
                good = 1;
                push_ev(EV_GOOD, pk[0], pk[1] * 256 + pk[2], pending);
                pending = 1;
            end else begin
                push_ev(EV_CHK, 0, 0, 0);
            end
        end
        if (ack_with && !good) pending = 0;
    endfunction

    task automatic send(input logic [7:0] b, input int gap, input bit ack_with);
        int w;
        bit hold;
        model_byte(int'(b), gap, ack_with);
        repeat (gap) begin @(posedge clk); #1; end
        rx_data     = b;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = ack_with;
        w = 0;
        do begin @(posedge clk); #1; w++; end while (!clr_rx_rdy && w < 8);
        check("clr_rx_rdy pulse", 32'(clr_rx_rdy), 32'd1);
        clr_cmd_rdy = 1'b0;
        hold = ($urandom_range(0, 3) == 0);
        if (!hold) rx_rdy = 1'b0;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        check("clr_rx_rdy single", 32'(clr_rx_rdy), 32'd0);
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [15:0] d, input bit corrupt,
                            input bit ack_chk);
        logic [7:0] s;
        logic [7:0] k;
        s = c + d[15:8] + d[7:0];
        k = ~s;
        if (corrupt) k = k ^ 8'(1 << $urandom_range(0, 7));
        send(SYNC, 0, 0);
        send(c, 0, 0);
        send(d[15:8], 0, 0);
        send(d[7:0], 0, 0);
        send(k, 0, ack_chk);
    endtask

    task automatic ack();
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        pending = 0;
        check("cmd_rdy after ack", 32'(cmd_rdy), 32'd0);
    endtask

    task automatic flush();
        if (pos > 0) push_ev(EV_TO, 0, 0, 0);
        pos = 0;
        repeat (T + 4) begin @(posedge clk); #1; end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " clr_rx_rdy"}, 32'(clr_rx_rdy), 0);
        check({tag, " cmd"},        32'(cmd), 0);
        check({tag, " data"},       32'(data), 0);
        check({tag, " cmd_rdy"},    32'(cmd_rdy), 0);
        check({tag, " chk_err"},    32'(chk_err), 0);
        check({tag, " timeout"},    32'(timeout), 0);
        check({tag, " overrun"},    32'(overrun), 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        rx_rdy = 1'b0;
        #1;
        check_zero_outputs("async reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        pos     = 0;
        pending = 0;
        check("queue empty at reset", 32'(exp_q.size()), 0);
    endtask

    // Monitor: every visible event is matched against the next expectation.
    initial begin
        bit   prev = 0;
        bit   good_seen;
        int   kind;
        ev_t  e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 0;
            end else begin
                good_seen = (cmd_rdy && !prev) || overrun;
                if (int'(good_seen) + int'(chk_err) + int'(timeout) > 1) begin
                    nvec++; nerr++;
                    $display("FAIL event overlap: good=%0d chk_err=%0d timeout=%0d", good_seen, chk_err, timeout);
                end else if (good_seen || chk_err || timeout) begin
                    kind = good_seen ? EV_GOOD : (chk_err ? EV_CHK : EV_TO);
                    if (exp_q.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected event: got kind %0d expected none", kind);
                    end else begin
                        e = exp_q.pop_front();
                        $display("pkt kind=%0d cmd=%02h data=%04h overrun=%0d", kind, cmd, data, overrun);
                        check("event kind", 32'(kind), 32'(e.kind));
                        if (e.kind == 2'(EV_GOOD) && kind == EV_GOOD) begin
                            check("cmd", 32'(cmd), 32'(e.cmd));
                            check("data", 32'(data), 32'(e.data));
                            check("overrun", 32'(overrun), 32'(e.ovr));
                        end
                    end
                end
                prev = cmd_rdy;
            end
        end
    end

    initial begin
        int sel;
        int g;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good packet
        send_pkt(8'h05, 16'h1234, 0, 0);
        check("cmd_rdy good", 32'(cmd_rdy), 1);
        ack();
        // Bad checksum then good packet
        send(8'hA5, 0, 0); send(8'h05, 0, 0); send(8'h12, 0, 0); send(8'h34, 0, 0); send(8'hB5, 0, 0);
        check("cmd_rdy after bad", 32'(cmd_rdy), 0);
        send_pkt(8'h05, 16'h1234, 0, 0);
        ack();
        // Garbage then sync
        send(8'h00, 0, 0); send(8'hFF, 1, 0);
        send(8'hA5, 0, 0); send(8'h01, 2, 0); send(8'h00, 0, 0); send(8'h00, 0, 0); send(8'hFE, 0, 0);
        check("cmd garbage", 32'(cmd), 32'h01);
        check("data garbage", 32'(data), 0);
        ack();
        // Timeout then good packet
        send(8'hA5, 0, 0); send(8'h05, 0, 0);
        flush();
        send(8'hA5, 0, 0); send(8'h07, 0, 0); send(8'h00, 0, 0); send(8'h01, 0, 0); send(8'hF7, 0, 0);
        // Overrun, then set-wins, then lone ack
        send_pkt(8'h01, 16'h0000, 0, 0);
        check("data after overrun", 32'(data), 32'h0000);
        ack();
        send_pkt(8'h05, 16'h1234, 0, 1);
        check("cmd_rdy set wins", 32'(cmd_rdy), 1);
        ack();
        // Timeout boundary: byte at the expiry cycle wins, one cycle later it does not
        send(8'hA5, 0, 0); send(8'h09, T - 2, 0); send(8'hAA, 0, 0); send(8'h55, 0, 0);
        send(8'h01, 0, 0);
        send(8'hA5, 0, 0); send(8'h09, T - 1, 0);
        flush();
        // Reset mid-packet
        send(8'hA5, 0, 0); send(8'h05, 0, 0); send(8'h12, 0, 0);
        do_reset();
        send_pkt(8'h07, 16'h0001, 0, 0);
        ack();

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                send_pkt(8'($urandom), 16'($urandom), 0, ($urandom_range(0, 7) == 0));
            end else if (sel == 6) begin
                send_pkt(8'($urandom), 16'($urandom), 1, 0);
            end else if (sel == 7) begin
                send(8'($urandom), $urandom_range(0, 3), 0);
            end else begin
                g = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(T - 3, T);
                send(SYNC, 0, 0);
                send(8'($urandom), g, 0);
                send(8'($urandom), $urandom_range(0, 2), 0);
            end
            if (pos == 0 && $urandom_range(0, 2) == 0) ack();
        end
        flush();
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
